// File: rtl/branch_pkg.sv
// Shared encodings, FSM states and stall constants for the branch controller.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_BEQ   = 3'd1,
    BR_BNE   = 3'd2,
    BR_BGTZ  = 3'd3,
    BR_BLTZ  = 3'd4,
    BR_BGEZ  = 3'd5,
    BR_BLEZ  = 3'd6,
    BR_NONE7 = 3'd7
  } br_type_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [1:0] LOAD_EX_STALL = 2'd2;
  localparam logic [1:0] ALU_EX_STALL  = 2'd1;

  function automatic logic is_branch(input logic [2:0] t);
    return (t >= BR_BEQ) && (t <= BR_BLEZ);
  endfunction

  function automatic logic uses_rt(input logic [2:0] t);
    return (t == BR_BEQ) || (t == BR_BNE);
  endfunction

  // Register 0 is hardwired, so it can never carry a dependency.
  function automatic logic src_hit(input logic [4:0] src, input logic [4:0] wa);
    return (src != 5'd0) && (src == wa);
  endfunction

endpackage

// File: rtl/branch_stat_ctr.sv
// Saturating statistics counter with enable.
module branch_stat_ctr #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [STAT_W-1:0] cnt
);

  logic [STAT_W-1:0] cnt_r;

  // Count enabled cycles, holding at all-ones once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != {STAT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch hazard controller. Define BRANCH_STATS_EN to build the
// statistics counters; otherwise the stat ports are tied to zero.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [2:0]        id_branchType,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  input  logic [4:0]        ex_wa,
  input  logic              mem_memRead,
  input  logic [4:0]        mem_wa,
  input  logic              branchAvail,
  input  logic              ext_flush,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              pc_sel,
  output logic              flush_if,
  output logic [STAT_W-1:0] stat_total,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_stall
);

  state_t     state_r, state_nxt_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic [1:0] n_s;
  logic       br_s, rt_used_s, dep_ex_s, dep_mem_s;
  logic       stall_s, pc_s;

  assign br_s      = id_valid && is_branch(id_branchType);
  assign rt_used_s = uses_rt(id_branchType);
  assign dep_ex_s  = ex_regWrite &&
                     (src_hit(id_rs, ex_wa) || (rt_used_s && src_hit(id_rt, ex_wa)));
  assign dep_mem_s = mem_memRead &&
                     (src_hit(id_rs, mem_wa) || (rt_used_s && src_hit(id_rt, mem_wa)));

  // Worst-case stall count for the branch sitting in ID.
  always_comb begin
    n_s = 2'd0;
    if (dep_ex_s && ex_memRead) begin
      n_s = LOAD_EX_STALL;
    end else if (dep_ex_s || dep_mem_s) begin
      n_s = ALU_EX_STALL;
    end else begin
      n_s = 2'd0;
    end
  end

  // Next state and hazard outputs; the counter holds the stall cycles still
  // owed including the current one, so exactly N stall cycles are issued.
  always_comb begin
    state_nxt_s = IDLE;
    cnt_nxt_s   = 2'd0;
    stall_s     = 1'b0;
    pc_s        = 1'b0;
    if (!rst_n || ext_flush || !br_s) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (n_s == 2'd0) begin
            pc_s = branchAvail;
          end else begin
            stall_s     = 1'b1;
            cnt_nxt_s   = n_s - 2'd1;
            state_nxt_s = (n_s == 2'd1) ? RESOLVE : STALL;
          end
        end
        STALL: begin
          stall_s = 1'b1;
          if (cnt_r > 2'd1) begin
            cnt_nxt_s   = cnt_r - 2'd1;
            state_nxt_s = STALL;
          end else begin
            cnt_nxt_s   = 2'd0;
            state_nxt_s = RESOLVE;
          end
        end
        RESOLVE: begin
          pc_s = branchAvail;
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 2'd0;
        end
      endcase
    end
  end

  // FSM state and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign stall_id  = stall_s;
  assign bubble_ex = stall_s;
  assign pc_sel    = pc_s;
  assign flush_if  = pc_s;

`ifdef BRANCH_STATS_EN
  logic resolve_s;
  assign resolve_s = rst_n && !ext_flush && br_s &&
                     ((state_r == RESOLVE) || ((state_r == IDLE) && (n_s == 2'd0)));

  branch_stat_ctr #(.STAT_W(STAT_W)) u_stat_total (
    .clk(clk), .rst_n(rst_n), .en(resolve_s), .cnt(stat_total)
  );
  branch_stat_ctr #(.STAT_W(STAT_W)) u_stat_taken (
    .clk(clk), .rst_n(rst_n), .en(resolve_s && branchAvail), .cnt(stat_taken)
  );
  branch_stat_ctr #(.STAT_W(STAT_W)) u_stat_stall (
    .clk(clk), .rst_n(rst_n), .en(stall_s), .cnt(stat_stall)
  );
`else
  assign stat_total = '0;
  assign stat_taken = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: the driver queues expected responses,
// a negedge monitor pops and compares them.
module tb_branch_ctrl;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] SAT = 32'hFFFF_FFFF;

  logic        clk, rst_n, id_valid, ex_regWrite, ex_memRead, mem_memRead;
  logic        branchAvail, ext_flush;
  logic [2:0]  id_branchType;
  logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
  logic        stall_id, bubble_ex, pc_sel, flush_if;
  logic [31:0] stat_total, stat_taken, stat_stall;

  branch_ctrl #(.STAT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_branchType(id_branchType),
    .id_rs(id_rs), .id_rt(id_rt), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_wa(ex_wa), .mem_memRead(mem_memRead), .mem_wa(mem_wa),
    .branchAvail(branchAvail), .ext_flush(ext_flush), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .pc_sel(pc_sel), .flush_if(flush_if),
    .stat_total(stat_total), .stat_taken(stat_taken), .stat_stall(stat_stall)
  );

  typedef struct {
    string       nm;
    logic        stall;
    logic        pc;
    logic [31:0] tot;
    logic [31:0] tak;
    logic [31:0] stl;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle and sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".stall_id"},   {31'd0, stall_id},  {31'd0, e.stall});
        chk({e.nm, ".bubble_ex"},  {31'd0, bubble_ex}, {31'd0, e.stall});
        chk({e.nm, ".pc_sel"},     {31'd0, pc_sel},    {31'd0, e.pc});
        chk({e.nm, ".flush_if"},   {31'd0, flush_if},  {31'd0, e.pc});
        chk({e.nm, ".stat_total"}, stat_total, e.tot);
        chk({e.nm, ".stat_taken"}, stat_taken, e.tak);
        chk({e.nm, ".stat_stall"}, stat_stall, e.stl);
      end
    end
  end

  // exk: 0 nothing in EX, 1 ALU op writing ex_wa, 2 load writing ex_wa.
  task automatic cyc(input string nm, input logic v, input logic [2:0] ty,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] exk, input logic [4:0] exwa,
                     input logic mld, input logic [4:0] mwa,
                     input logic av, input logic fl, input logic es, input logic ep,
                     input logic [31:0] et, input logic [31:0] ek, input logic [31:0] eq);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_branchType = ty; id_rs = rs; id_rt = rt;
    ex_regWrite = (exk != 2'd0); ex_memRead = (exk == 2'd2); ex_wa = exwa;
    mem_memRead = mld; mem_wa = mwa; branchAvail = av; ext_flush = fl;
    e.nm = nm; e.stall = es; e.pc = ep;
    e.tot = STATS ? et : 32'd0;
    e.tak = STATS ? ek : 32'd0;
    e.stl = STATS ? eq : 32'd0;
    q.push_back(e);
  endtask

  task automatic outs_zero(input string nm);
    chk({nm, ".stall_id"},   {31'd0, stall_id},  32'd0);
    chk({nm, ".bubble_ex"},  {31'd0, bubble_ex}, 32'd0);
    chk({nm, ".pc_sel"},     {31'd0, pc_sel},    32'd0);
    chk({nm, ".flush_if"},   {31'd0, flush_if},  32'd0);
    chk({nm, ".stat_total"}, stat_total, 32'd0);
    chk({nm, ".stat_stall"}, stat_stall, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_branchType = 3'd0; id_rs = 5'd0; id_rt = 5'd0;
    ex_regWrite = 1'b0; ex_memRead = 1'b0; ex_wa = 5'd0; mem_memRead = 1'b0;
    mem_wa = 5'd0; branchAvail = 1'b0; ext_flush = 1'b0;
    #1;
    outs_zero("reset_hold");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    //   name        v  ty    rs     rt     exk   exwa   mld   mwa    av    fl    stall pc    tot    tak    stl
    cyc("idle0",    1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    cyc("t1_beq",   1'b1, 3'd1, 5'd5, 5'd5, 2'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    cyc("t1_after", 1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
    cyc("t2_st1",   1'b1, 3'd2, 5'd1, 5'd8, 2'd2, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 32'd0);
    cyc("t2_st2",   1'b1, 3'd2, 5'd1, 5'd8, 2'd2, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 32'd1);
    cyc("t2_res",   1'b1, 3'd2, 5'd1, 5'd8, 2'd2, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2);
    cyc("t2_after", 1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd1, 32'd2);
    cyc("t3_st",    1'b1, 3'd3, 5'd3, 5'd0, 2'd1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 32'd1, 32'd2);
    cyc("t3_res",   1'b1, 3'd3, 5'd3, 5'd0, 2'd1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 32'd1, 32'd3);
    cyc("t3_r0",    1'b1, 3'd4, 5'd0, 5'd0, 2'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 32'd2, 32'd3);
    cyc("t3_after", 1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 32'd3, 32'd3);
    cyc("mem_st",   1'b1, 3'd1, 5'd7, 5'd9, 2'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4, 32'd3, 32'd3);
    cyc("mem_res",  1'b1, 3'd1, 5'd7, 5'd9, 2'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 32'd4, 32'd3, 32'd4);
    cyc("rt_ign",   1'b1, 3'd5, 5'd2, 5'd6, 2'd2, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd4, 32'd4);
    cyc("t4_st",    1'b1, 3'd2, 5'd8, 5'd1, 2'd2, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd6, 32'd4, 32'd4);
    cyc("t4_flush", 1'b1, 3'd2, 5'd8, 5'd1, 2'd2, 5'd8, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd6, 32'd4, 32'd5);
    cyc("t4_idle",  1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd4, 32'd5);
    cyc("ab_st",    1'b1, 3'd6, 5'd4, 5'd0, 2'd1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd6, 32'd4, 32'd5);
    cyc("ab_drop",  1'b0, 3'd6, 5'd4, 5'd0, 2'd1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd4, 32'd6);
    cyc("ab_idle",  1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd4, 32'd6);
    cyc("t5_st1",   1'b1, 3'd2, 5'd8, 5'd1, 2'd2, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd6, 32'd4, 32'd6);

    // Asynchronous reset in the middle of the second stall cycle.
    @(posedge clk);
    #1;
    chk("t5_pre.stall_id", {31'd0, stall_id}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    outs_zero("t5_async");
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    outs_zero("t5_held");
    #2 rst_n = 1'b1;

    cyc("t5_new1",  1'b1, 3'd2, 5'd8, 5'd1, 2'd2, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    cyc("t5_new2",  1'b1, 3'd2, 5'd8, 5'd1, 2'd2, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd1);
    cyc("t5_res",   1'b1, 3'd2, 5'd8, 5'd1, 2'd2, 5'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd2);
    cyc("t5_after", 1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2);

    // Preload counters to all-ones and confirm they saturate.
    @(posedge clk);
    #1;
`ifdef BRANCH_STATS_EN
    force dut.u_stat_total.cnt_r = SAT;
    force dut.u_stat_taken.cnt_r = SAT;
    force dut.u_stat_stall.cnt_r = SAT;
    #1;
    release dut.u_stat_total.cnt_r;
    release dut.u_stat_taken.cnt_r;
    release dut.u_stat_stall.cnt_r;
`endif
    cyc("t6_take",  1'b1, 3'd1, 5'd1, 5'd2, 2'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, SAT, SAT, SAT);
    cyc("t6_st",    1'b1, 3'd3, 5'd3, 5'd0, 2'd1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, SAT, SAT, SAT);
    cyc("t6_res",   1'b1, 3'd3, 5'd3, 5'd0, 2'd1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, SAT, SAT, SAT);
    cyc("t6_after", 1'b0, 3'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SAT, SAT, SAT);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain.queue_left", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
